// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM/IO port between instruction fetch (word reads)
// and the store/load buffer (byte/half/word loads and stores), one byte per cycle.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on ties;
// without it the store/load buffer always wins a tie.
module mem_arbiter #(
   parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        jump_rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_valid,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_wr,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_valid,
   output logic [31:0] ls_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full,
   output logic        busy
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] IF_RD = 3'd1;
   localparam logic [2:0] LS_RD = 3'd2;
   localparam logic [2:0] LS_WR = 3'd3;
   localparam logic [2:0] COOL  = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [2:0]  len_q, len_d;     // bytes in the access: 1, 2 or 4
   logic [2:0]  step_q, step_d;   // reads: edges since grant; writes: next byte index
   logic [31:0] base_q, base_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] buf_q, buf_d;     // read bytes assembled so far
   logic [31:0] mem_a_q, mem_a_d;
   logic [7:0]  mem_dout_q, mem_dout_d;
   logic        mem_wr_q, mem_wr_d;
   logic        if_valid_q, if_valid_d;
   logic        ls_valid_q, ls_valid_d;
   logic [31:0] if_data_q, if_data_d;
   logic [31:0] ls_rdata_q, ls_rdata_d;
   logic        busy_q, busy_d;

   logic        ls_win;
   logic [2:0]  ls_len;
   logic [31:0] nxt_addr;
   logic        ls_stall, nxt_stall;
   logic [1:0]  rx_idx;

   assign ls_len    = (ls_size == 2'b00) ? 3'd1 : (ls_size == 2'b01) ? 3'd2 : 3'd4;
   assign nxt_addr  = base_q + {29'd0, step_q};
   assign ls_stall  = io_buffer_full && (ls_addr[17:16] == IO_ADDR_HI);
   assign nxt_stall = io_buffer_full && (nxt_addr[17:16] == IO_ADDR_HI);
   // Byte captured at step k was addressed two edges earlier.
   assign rx_idx    = step_q[1:0] - 2'd2;

`ifdef MEM_ARB_RR_EN
   logic rr_q;  // 1: SLB finished last, so IF wins the next tie

   // Track which requester completed last; resets favouring SLB.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_q <= 1'b0;
      end else if (rdy && (if_valid_d || ls_valid_d)) begin
         rr_q <= ls_valid_d;
      end
   end

   assign ls_win = ls_req && !(if_req && rr_q);
`else
   assign ls_win = ls_req;
`endif

   // Next-state and registered-output logic; everything holds while rdy is low.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      step_d     = step_q;
      base_d     = base_q;
      wdata_d    = wdata_q;
      buf_d      = buf_q;
      mem_a_d    = mem_a_q;
      mem_dout_d = mem_dout_q;
      mem_wr_d   = mem_wr_q;
      if_valid_d = if_valid_q;
      ls_valid_d = ls_valid_q;
      if_data_d  = if_data_q;
      ls_rdata_d = ls_rdata_q;
      if (rdy) begin
         mem_wr_d   = 1'b0;
         if_valid_d = 1'b0;
         ls_valid_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (!jump_rst && (ls_req || if_req)) begin
                  buf_d  = 32'd0;
                  step_d = 3'd1;
                  if (ls_win) begin
                     base_d  = ls_addr;
                     len_d   = ls_len;
                     wdata_d = ls_wdata;
                     mem_a_d = ls_addr;
                     if (ls_wr) begin
                        state_d = LS_WR;
                        if (ls_stall) begin
                           step_d = 3'd0;
                        end else begin
                           mem_wr_d   = 1'b1;
                           mem_dout_d = ls_wdata[7:0];
                        end
                     end else begin
                        state_d = LS_RD;
                     end
                  end else begin
                     base_d  = if_addr;
                     len_d   = 3'd4;
                     mem_a_d = if_addr;
                     state_d = IF_RD;
                  end
               end
            end
            IF_RD, LS_RD: begin
               if (jump_rst) begin
                  state_d = IDLE;
               end else begin
                  if (step_q < len_q) mem_a_d = nxt_addr;
                  if (step_q >= 3'd2) buf_d[{rx_idx, 3'b000} +: 8] = mem_din;
                  if (step_q == len_q + 3'd1) begin
                     state_d = COOL;
                     if (state_q == IF_RD) begin
                        if_valid_d = 1'b1;
                        if_data_d  = buf_d;
                     end else begin
                        ls_valid_d = 1'b1;
                        ls_rdata_d = buf_d;
                     end
                  end
                  step_d = step_q + 3'd1;
               end
            end
            LS_WR: begin
               // Stores are committed, so a flush does not stop them.
               if (step_q == len_q) begin
                  ls_valid_d = 1'b1;
                  state_d    = COOL;
               end else begin
                  mem_a_d = nxt_addr;
                  if (!nxt_stall) begin
                     mem_wr_d   = 1'b1;
                     mem_dout_d = wdata_q[{step_q[1:0], 3'b000} +: 8];
                     step_d     = step_q + 3'd1;
                  end
               end
            end
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         len_q      <= 3'd0;
         step_q     <= 3'd0;
         base_q     <= 32'd0;
         wdata_q    <= 32'd0;
         buf_q      <= 32'd0;
         mem_a_q    <= 32'd0;
         mem_dout_q <= 8'd0;
         mem_wr_q   <= 1'b0;
         if_valid_q <= 1'b0;
         ls_valid_q <= 1'b0;
         if_data_q  <= 32'd0;
         ls_rdata_q <= 32'd0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         step_q     <= step_d;
         base_q     <= base_d;
         wdata_q    <= wdata_d;
         buf_q      <= buf_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
         mem_wr_q   <= mem_wr_d;
         if_valid_q <= if_valid_d;
         ls_valid_q <= ls_valid_d;
         if_data_q  <= if_data_d;
         ls_rdata_q <= ls_rdata_d;
         busy_q     <= busy_d;
      end
   end

   assign if_valid = if_valid_q;
   assign if_data  = if_data_q;
   assign ls_valid = ls_valid_q;
   assign ls_rdata = ls_rdata_q;
   assign mem_dout = mem_dout_q;
   assign mem_a    = mem_a_q;
   assign mem_wr   = mem_wr_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-wide RAM model plus scoreboards for RAM writes and both
// valid channels; each scenario task also checks cycle timing.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        jump_rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'd0;
   logic        ls_req = 1'b0;
   logic        ls_wr = 1'b0;
   logic [1:0]  ls_size = 2'b00;
   logic [31:0] ls_addr = 32'd0;
   logic [31:0] ls_wdata = 32'd0;
   logic [7:0]  mem_din = 8'h00;
   logic        io_buffer_full = 1'b0;
   logic        if_valid, ls_valid, mem_wr, busy;
   logic [31:0] if_data, ls_rdata, mem_a;
   logic [7:0]  mem_dout;

   mem_arbiter dut (
      .clk(clk), .rst(rst), .rdy(rdy), .jump_rst(jump_rst),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
      .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full), .busy(busy)
   );

   always #5 clk = ~clk;

   // Read-only RAM image; the top level gates the RAM with rdy.
   logic [7:0] ram [logic [31:0]];
   always @(posedge clk) begin
      if (rdy) begin
         if (ram.exists(mem_a)) mem_din <= ram[mem_a];
         else                   mem_din <= 8'h00;
      end
   end

   logic [31:0] exp_if[$];
   logic [32:0] exp_ls[$];   // {check data, data}
   logic [39:0] exp_wr[$];   // {addr, byte}
   int n_vec  = 0;
   int n_fail = 0;
   bit got_if, got_ls;
   logic        p_wr = 1'b0, p_ifv = 1'b0, p_lsv = 1'b0;
   logic [31:0] p_a = 32'd0;
   logic [7:0]  p_dout = 8'd0;

   // Advance one clock, sample #1 after the edge and run the scoreboards.
   task automatic tick();
      logic        edge_rdy;
      logic [39:0] w;
      logic [32:0] l;
      logic [31:0] e;
      edge_rdy = rdy;
      @(posedge clk);
      #1;
      got_if = 0;
      got_ls = 0;
      if (p_wr && edge_rdy && rst) begin
         n_vec++;
         if (exp_wr.size() == 0) begin
            n_fail++;
            $display("FAIL ram_write: got addr=%h data=%h, required no write", p_a, p_dout);
         end else begin
            w = exp_wr.pop_front();
            if ({p_a, p_dout} !== w) begin
               n_fail++;
               $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                        p_a, p_dout, w[39:8], w[7:0]);
            end
         end
      end
      if (if_valid && !p_ifv) begin
         got_if = 1;
         n_vec++;
         if (exp_if.size() == 0) begin
            n_fail++;
            $display("FAIL if_valid: got pulse data=%h, required no pulse", if_data);
         end else begin
            e = exp_if.pop_front();
            if (if_data !== e) begin
               n_fail++;
               $display("FAIL if_data: got %h, required %h", if_data, e);
            end
         end
      end
      if (ls_valid && !p_lsv) begin
         got_ls = 1;
         n_vec++;
         if (exp_ls.size() == 0) begin
            n_fail++;
            $display("FAIL ls_valid: got pulse data=%h, required no pulse", ls_rdata);
         end else begin
            l = exp_ls.pop_front();
            if (l[32] && ls_rdata !== l[31:0]) begin
               n_fail++;
               $display("FAIL ls_rdata: got %h, required %h", ls_rdata, l[31:0]);
            end
         end
      end
      p_wr   = mem_wr;
      p_a    = mem_a;
      p_dout = mem_dout;
      p_ifv  = if_valid;
      p_lsv  = ls_valid;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) tick();
      n_vec++;
      if ({if_valid, ls_valid, mem_wr, busy} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b, required 0000", {if_valid, ls_valid, mem_wr, busy});
      end
      n_vec++;
      if (mem_a !== 32'd0 || mem_dout !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_bus: got a=%h dout=%h, required 0/0", mem_a, mem_dout);
      end
      n_vec++;
      if (if_data !== 32'd0 || ls_rdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_data: got %h/%h, required 0/0", if_data, ls_rdata);
      end
      rst = 1'b1;
      tick();
      n_vec++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_priority();
      int t_ls1, t_ls2, t_if, n_ls, x_ls2, x_if;
      ram[32'h10]  = 8'h80;
      ram[32'h11]  = 8'h5A;
      ram[32'h400] = 8'h11;
      ram[32'h401] = 8'h22;
      ram[32'h402] = 8'h33;
      ram[32'h403] = 8'h44;
      exp_ls.push_back({1'b1, 32'h0000_0080});
      exp_ls.push_back({1'b1, 32'h0000_005A});
      exp_if.push_back(32'h4433_2211);
`ifdef MEM_ARB_RR_EN
      x_ls2 = 13;
      x_if  = 9;
`else
      x_ls2 = 6;
      x_if  = 13;
`endif
      t_ls1 = -1; t_ls2 = -1; t_if = -1; n_ls = 0;
      ls_req = 1; ls_wr = 0; ls_size = 2'b00; ls_addr = 32'h10;
      if_req = 1; if_addr = 32'h400;
      for (int t = 0; t <= 16; t++) begin
         tick();
         if (t == 0) begin
            n_vec++;
            if (mem_a !== 32'h10 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL prio_grant: a=%h busy=%b, required 00000010/1", mem_a, busy);
            end
         end
         if (got_ls) begin
            if (n_ls == 0) t_ls1 = t;
            else           t_ls2 = t;
            n_ls++;
            ls_req = 0;
         end
         if (got_if) begin
            t_if   = t;
            if_req = 0;
         end
         if (t == 3) begin
            ls_req  = 1;
            ls_addr = 32'h11;
         end
      end
      n_vec++;
      if (t_ls1 != 2 || t_ls2 != x_ls2 || t_if != x_if) begin
         n_fail++;
         $display("FAIL prio_timing: ls at %0d,%0d if at %0d, required 2,%0d and %0d",
                  t_ls1, t_ls2, t_if, x_ls2, x_if);
      end
   endtask

   task automatic test_if_read();
      int t_if;
      ram[32'h100] = 8'h13;
      ram[32'h101] = 8'h00;
      ram[32'h102] = 8'h00;
      ram[32'h103] = 8'h00;
      exp_if.push_back(32'h0000_0013);
      t_if = -1;
      if_req = 1; if_addr = 32'h100;
      for (int t = 0; t <= 8; t++) begin
         tick();
         if (t == 0) begin
            n_vec++;
            if ({busy, mem_wr} !== 2'b10 || mem_a !== 32'h100) begin
               n_fail++;
               $display("FAIL if_grant: busy=%b wr=%b a=%h, required 1/0/00000100",
                        busy, mem_wr, mem_a);
            end
         end
         if (t == 3) begin
            n_vec++;
            if (mem_a !== 32'h103) begin
               n_fail++;
               $display("FAIL if_addr_step: a=%h, required 00000103", mem_a);
            end
         end
         if (t_if >= 0 && t == t_if + 1) begin
            n_vec++;
            if (busy !== 1'b0 || if_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL if_after_cool: busy=%b valid=%b, required 0/0", busy, if_valid);
            end
         end
         if (got_if) begin
            t_if   = t;
            if_req = 0;
            n_vec++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL if_cool: busy=%b, required 1", busy);
            end
         end
      end
      n_vec++;
      if (t_if != 5) begin
         n_fail++;
         $display("FAIL if_latency: valid at %0d, required 5", t_if);
      end
   endtask

   task automatic test_half_store();
      int t_ls;
      exp_wr.push_back({32'h200, 8'hDD});
      exp_wr.push_back({32'h201, 8'hCC});
      exp_ls.push_back({1'b0, 32'd0});
      t_ls = -1;
      ls_req = 1; ls_wr = 1; ls_size = 2'b01; ls_addr = 32'h200; ls_wdata = 32'hAABB_CCDD;
      for (int t = 0; t <= 5; t++) begin
         tick();
         if (t == 0) begin
            n_vec++;
            if (mem_wr !== 1'b1 || mem_a !== 32'h200 || mem_dout !== 8'hDD) begin
               n_fail++;
               $display("FAIL store_first: wr=%b a=%h d=%h, required 1/00000200/dd",
                        mem_wr, mem_a, mem_dout);
            end
         end
         if (got_ls) begin
            t_ls   = t;
            ls_req = 0;
         end
      end
      n_vec++;
      if (t_ls != 2 || exp_wr.size() != 0) begin
         n_fail++;
         $display("FAIL store_done: valid at %0d, %0d writes missing, required 2 and 0",
                  t_ls, exp_wr.size());
      end
   endtask

   task automatic test_jump();
      int t_ls;
      ls_wr = 0;
      if_req = 1; if_addr = 32'h100; jump_rst = 1;
      tick();
      n_vec++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL jump_idle_grant: busy=%b, required 0", busy);
      end
      jump_rst = 0;
      tick();
      tick();
      jump_rst = 1;
      if_req   = 0;
      tick();
      n_vec++;
      if ({busy, if_valid, mem_wr} !== 3'b000) begin
         n_fail++;
         $display("FAIL jump_abort: busy/valid/wr=%b, required 000", {busy, if_valid, mem_wr});
      end
      jump_rst = 0;
      repeat (6) tick();
      // A committed word store keeps going through a flush.
      exp_wr.push_back({32'h500, 8'h01});
      exp_wr.push_back({32'h501, 8'h02});
      exp_wr.push_back({32'h502, 8'h03});
      exp_wr.push_back({32'h503, 8'h04});
      exp_ls.push_back({1'b0, 32'd0});
      t_ls = -1;
      ls_req = 1; ls_wr = 1; ls_size = 2'b10; ls_addr = 32'h500; ls_wdata = 32'h0403_0201;
      for (int t = 0; t <= 7; t++) begin
         tick();
         jump_rst = (t == 0);
         if (got_ls) begin
            t_ls   = t;
            ls_req = 0;
         end
      end
      n_vec++;
      if (t_ls != 4 || exp_wr.size() != 0) begin
         n_fail++;
         $display("FAIL jump_store: valid at %0d, %0d writes missing, required 4 and 0",
                  t_ls, exp_wr.size());
      end
   endtask

   task automatic test_io_stall();
      int t_ls, idle_cnt;
      exp_wr.push_back({32'h3_0000, 8'h77});
      exp_ls.push_back({1'b0, 32'd0});
      t_ls = -1; idle_cnt = 0;
      io_buffer_full = 1;
      ls_req = 1; ls_wr = 1; ls_size = 2'b00; ls_addr = 32'h3_0000; ls_wdata = 32'h0000_0077;
      for (int t = 0; t <= 7; t++) begin
         tick();
         if (t <= 2 && mem_wr === 1'b0) idle_cnt++;
         if (t == 2) io_buffer_full = 0;
         if (t == 3) begin
            n_vec++;
            if (mem_wr !== 1'b1 || mem_a !== 32'h3_0000) begin
               n_fail++;
               $display("FAIL io_release: wr=%b a=%h, required 1/00030000", mem_wr, mem_a);
            end
         end
         if (got_ls) begin
            t_ls   = t;
            ls_req = 0;
         end
      end
      n_vec++;
      if (idle_cnt != 3 || t_ls != 4) begin
         n_fail++;
         $display("FAIL io_stall: %0d held cycles, valid at %0d, required 3 and 4",
                  idle_cnt, t_ls);
      end
   endtask

   task automatic test_rdy_stall();
      int t_if;
      exp_if.push_back(32'h4433_2211);
      t_if = -1;
      ls_wr = 0;
      if_req = 1; if_addr = 32'h400;
      for (int t = 0; t <= 12; t++) begin
         tick();
         if (t == 1) rdy = 0;
         if (t == 5) rdy = 1;
         if (t == 3) begin
            n_vec++;
            if (mem_a !== 32'h401 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL rdy_hold: a=%h busy=%b, required 00000401/1", mem_a, busy);
            end
         end
         if (got_if) begin
            t_if   = t;
            if_req = 0;
         end
      end
      n_vec++;
      if (t_if != 9) begin
         n_fail++;
         $display("FAIL rdy_latency: valid at %0d, required 9", t_if);
      end
   endtask

   task automatic test_reset_mid();
      if_req = 1; if_addr = 32'h100;
      repeat (3) tick();
      #2;
      rst = 1'b0;
      #1;
      n_vec++;
      if ({if_valid, ls_valid, mem_wr, busy} !== 4'b0 || mem_a !== 32'd0 ||
          mem_dout !== 8'd0 || if_data !== 32'd0 || ls_rdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid: ctrl=%b a=%h d=%h if=%h ls=%h, required all zero",
                  {if_valid, ls_valid, mem_wr, busy}, mem_a, mem_dout, if_data, ls_rdata);
      end
      if_req = 0;
      p_wr = 0; p_ifv = 0; p_lsv = 0;
      tick();
      rst = 1'b1;
      repeat (2) tick();
      n_vec++;
      if (busy !== 1'b0 || if_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_idle: busy=%b valid=%b, required 0/0", busy, if_valid);
      end
   endtask

   initial begin
      test_reset();
      test_priority();
      test_if_read();
      test_half_store();
      test_jump();
      test_io_stall();
      test_rdy_stall();
      test_reset_mid();
      n_vec++;
      if (exp_if.size() + exp_ls.size() + exp_wr.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d/%0d/%0d entries left, required 0/0/0",
                  exp_if.size(), exp_ls.size(), exp_wr.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM/IO port between instruction fetch (word reads) and the store/load buffer (byte/half/word loads and stores).
- Sequences each multi-byte access byte by byte and assembles or splits the data.
- Handles branch-flush aborts and stalls IO-space stores while the IO buffer is full.
- Sits between IF/SLB and the top-level RAM interface.

Parameters:
IO_ADDR_HI, 2'b11, value of addr[17:16] that marks IO space (byte stores there obey io_buffer_full)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global enable; when low, all state holds
jump_rst  in  1  branch mispredict flush
if_req  in  1  IF read request, level, held until if_valid
if_addr  in  32  IF word address
if_valid  out  1  one-cycle pulse, if_data valid
if_data  out  32  little-endian assembled word
ls_req  in  1  SLB request, level, held until ls_valid
ls_wr  in  1  1=store, 0=load
ls_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
ls_addr  in  32  byte address
ls_wdata  in  32  store data, low bytes used
ls_valid  out  1  one-cycle pulse, load data ready / store done
ls_rdata  out  32  load data, zero-extended
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM byte address
mem_wr  out  1  1=write this cycle
io_buffer_full  in  1  IO write buffer full
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; if_valid=ls_valid=0; mem_wr=0; mem_a=0; mem_dout=0; if_data=ls_rdata=0; busy=0; counters cleared.
- States: IDLE, IF_RD, LS_RD, LS_WR, COOL. All outputs are registered.
- IDLE grant, evaluated on an edge with rdy=1 and jump_rst=0:
  - ls_req has priority over if_req (fixed priority unless the optional feature is enabled).
  - A grant latches base address, N bytes (1/2/4), and write data.
  - On the same edge: mem_a=base; for a store, mem_wr=1 and mem_dout=byte0.
- Read (IF_RD/LS_RD), grant on edge E0:
  - mem_a=base+k on edge Ek, k=0..N-1.
  - RAM returns byte k one cycle later; the controller captures it at edge E(k+2).
  - At edge E(N+1): valid pulses with the assembled data (byte0 in bits 7:0); go to COOL.
  - Latency is N+1 cycles: word=5, half=3, byte=2.
- Write (LS_WR):
  - One byte per cycle: mem_wr=1, mem_a=base+k, mem_dout=byte k.
  - At edge EN: mem_wr=0 and ls_valid pulses; go to COOL.
- IO stall: if mem_a[17:16]==IO_ADDR_HI and io_buffer_full=1 when the next write byte would be driven, drive mem_wr=0 and hold the byte counter until io_buffer_full=0. This also applies to the first byte in IDLE: the grant still occurs, but the write waits.
- COOL: exactly one cycle, requests ignored (the requester drops its level request that cycle); then IDLE. mem_wr=0 and valid outputs return to 0.
- jump_rst=1 on an edge:
  - IF_RD and LS_RD abort to IDLE at that edge, with no valid pulse, mem_wr=0.
  - LS_WR is never aborted: committed stores complete and pulse ls_valid.
  - In IDLE, no grant occurs on that edge.
- rdy=0: no state, counter, or output register changes (valid pulses extend). The top level gates the RAM with rdy.
- Address arithmetic is 32-bit, wraps modulo 2^32; no alignment requirement.
- Never more than one transaction in flight; mem_wr=1 only in LS_WR.

Optional Feature:
MEM_ARB_RR_EN:
- Defined: a round-robin priority bit toggles after each completed grant. When both requests are pending in IDLE, the requester not served last wins. The bit resets to favour SLB.
- Undefined: fixed SLB-over-IF priority; the bit is absent.

Test Plan:
- IF word read, if_addr=0x100, RAM bytes 13,00,00,00 -> if_valid pulses at edge E5, if_data=0x00000013, then COOL, then IDLE.
- SLB half store, addr=0x200, wdata=0xAABBCCDD -> mem_wr=1 at 0x200 (dout 0xDD) then 0x201 (0xCC), ls_valid at E2; no write to 0x202.
- if_req and ls_req rise together (load byte at 0x10 = 0x80) -> SLB served first: ls_valid at E2, ls_rdata=0x00000080; IF word read starts after COOL. With MEM_ARB_RR_EN, a second simultaneous pair is served IF first.
- jump_rst at edge E2 of an IF read -> no if_valid, IDLE next; a store in progress hit by jump_rst at E1 still writes all 4 bytes and pulses ls_valid.
- Byte store to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr held 0 for 3 cycles, then a single write; ls_valid one cycle after that write.
- Async reset asserted mid word-read, and rdy=0 for 4 cycles mid-read -> reset: all outputs 0 immediately, state IDLE; rdy stall: latency extends by exactly 4 cycles with correct data.
